// File: rtl/div_seq_ctrl_pkg.sv
// Shared state codes and handshake constants for the iterative HI/LO divider.
package div_seq_ctrl_pkg;

  localparam int unsigned DIV_DATA_W   = 32;
  localparam int unsigned DoubleRegBus = 2 * DIV_DATA_W;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// One restoring-division iteration: shift {rem,quot} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] diff;

  // rem stays below divisor between steps, so the DATA_W+1 bit difference never overflows
  always_comb begin
    rem_sh = {rem_i, quot_i[DATA_W-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    quot_o = {quot_i[DATA_W-2:0], ~diff[DATA_W]};
    rem_o  = diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the DIV/DIVU iterative divider beside EX; stalls the pipe until the result is ready.
import div_seq_ctrl_pkg::*;

module div_seq_ctrl #(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int unsigned       ResW    = (DATA_W == DIV_DATA_W) ? DoubleRegBus : 2 * DATA_W;
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quot_q, quot_d;
  logic              sign1_q, sign1_d;
  logic              sign2_q, sign2_d;
  logic [ResW-1:0]   result_q, result_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] step_rem, step_quot;
  logic [DATA_W-1:0] rem_fix, quot_fix;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .quot_o    (step_quot)
  );

  // Signs were latched only for signed divides, so unsigned runs pass through untouched
  always_comb begin
    quot_fix = (sign1_q ^ sign2_q) ? -quot_q : quot_q;
    rem_fix  = sign1_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    sign1_d   = sign1_q;
    sign2_d   = sign2_q;
    result_d  = result_q;
    ready_d   = ready_q;

    unique case (state_q)
      DIV_FREE: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BYZERO;
          end else begin
            sign1_d   = signed_div_i & opdata1_i[DATA_W-1];
            sign2_d   = signed_div_i & opdata2_i[DATA_W-1];
            quot_d    = sign1_d ? -opdata1_i : opdata1_i;
            divisor_d = sign2_d ? -opdata2_i : opdata2_i;
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = DIV_ON;
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else begin
          rem_d    = '0;
          quot_d   = '0;
          result_d = '0;
          ready_d  = DivResultReady;
          state_d  = DIV_END;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q != CntLast) begin
          rem_d  = step_rem;
          quot_d = step_quot;
          cnt_d  = cnt_q + CNT_W'(1);
        end else begin
          result_d = {rem_fix, quot_fix};
          ready_d  = DivResultReady;
          state_d  = DIV_END;
        end
      end
      DIV_END: begin
        if (annul_i || start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      sign1_q   <= sign1_d;
      sign2_q   <= sign2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = (start_i == DivStart) & ~annul_i & (state_q != DIV_END);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: arithmetic reference model plus directed literal cases.
module tb_div_seq_ctrl;

  localparam int unsigned W = 32;

  logic           clk   = 1'b0;
  logic           rst   = 1'b0;
  logic           start = 1'b0;
  logic           annul = 1'b0;
  logic           sdiv  = 1'b0;
  logic [W-1:0]   op1   = '0;
  logic [W-1:0]   op2   = '0;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sdiv),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stall)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference quotient/remainder straight from integer division (truncating, rem takes dividend sign)
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'h0, a});
      lb = longint'({32'h0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Timing model: a divide is busy for a fixed number of cycles, then the result is held
  bit          m_busy   = 0;
  bit          m_ready  = 0;
  int          m_left   = 0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pend   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_ready = 0; m_left = 0; m_result = '0; m_pend = '0;
    end else if (m_ready) begin
      if (annul || !start) begin
        m_ready  = 0;
        m_result = '0;
      end
    end else if (m_busy) begin
      if (annul) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin
          m_busy   = 0;
          m_ready  = 1;
          m_result = m_pend;
        end
      end
    end else if (start && !annul) begin
      m_busy = 1;
      m_left = (op2 == '0) ? 1 : W + 1;
      m_pend = ref_div(sdiv, op1, op2);
    end
  end

  always @(negedge clk) begin
    check("cyc_ready", 64'(ready), 64'(m_ready));
    check("cyc_result", result, m_result);
    check("cyc_stall", 64'(stall), 64'(start & ~annul & ~m_ready));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string name, input bit s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    int lat = 0;
    int st  = 0;
    bit done = 0;
    sdiv = s; op1 = a; op2 = b; start = 1;
    for (int i = 0; i < 80 && !done; i++) begin
      @(negedge clk);
      if (stall) st++;
      @(posedge clk);
      #1;
      lat++;
      if (ready) done = 1;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_stall"}, 64'(st), 64'(exp_lat));
    check({name, "_res"}, result, exp);
  endtask

  task automatic end_div(input string name);
    start = 0;
    tick();
    check({name, "_drop_ready"}, 64'(ready), 64'h0);
    check({name, "_drop_res"}, result, 64'h0);
  endtask

  initial begin
    bit          s, got, annulled;
    logic [31:0] a, b;
    int          ann_at, hold;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'h0);
    check("rst_result", result, 64'h0);
    rst = 1;
    tick();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 34);
    end_div("divu_100_7");
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    end_div("div_m7_2");
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 34);
    end_div("div_7_m2");
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 34);
    end_div("div_min_m1");
    run_div("divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 34);
    end_div("divu_min_max");
    run_div("div_by0_s", 1'b1, 32'hDEAD_BEEF, 32'h0, 64'h0, 2);
    end_div("div_by0_s");
    run_div("div_by0_u", 1'b0, 32'd12345, 32'h0, 64'h0, 2);
    end_div("div_by0_u");

    // Annul ten cycles into ON, then issue a fresh divide immediately
    sdiv = 0; op1 = 32'd100; op2 = 32'd7; start = 1;
    repeat (11) tick();
    annul = 1;
    tick();
    annul = 0;
    check("annul_ready", 64'(ready), 64'h0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'h0, 32'd3}, 34);

    // Start held through END: result must stay put
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_ready", 64'(ready), 64'h1);
      check("hold_res", result, {32'h0, 32'd3});
    end
    end_div("divu_9_3");

    // Asynchronous reset in the middle of a run
    sdiv = 1; op1 = 32'h1234_5678; op2 = 32'd17; start = 1;
    repeat (20) tick();
    rst = 0;
    #1;
    check("midrst_ready", 64'(ready), 64'h0);
    check("midrst_res", result, 64'h0);
    start = 0;
    tick();
    rst = 1;
    tick();

    for (int t = 0; t < 30; t++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'h1;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      ann_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 36)) : 0;
      sdiv = s; op1 = a; op2 = b; start = 1;
      got = 0; annulled = 0;
      for (int i = 1; i <= 60 && !got && !annulled; i++) begin
        tick();
        op1 = $urandom;
        op2 = $urandom;
        if (i == ann_at) begin
          annul = 1;
          tick();
          annul = 0;
          start = 0;
          annulled = 1;
        end else if (ready) begin
          got = 1;
        end
      end
      if (!annulled) begin
        check("rnd_done", 64'(got), 64'h1);
        check("rnd_res", result, ref_div(s, a, b));
        hold = int'($urandom_range(0, 3));
        repeat (hold) tick();
        start = 0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
